// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder and its MMIO window.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int DMEM_DEPTH_DEF = 4096;
    localparam int TX_DEPTH_DEF   = 4;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        OFS_LED = 2'd0,
        OFS_CNT = 2'd1,
        OFS_TXD = 2'd2,
        OFS_TXS = 2'd3
    } mmio_ofs_e;

    // TX status word layout, bit 0 first from the right.
    typedef struct packed {
        logic [24:0] rsvd_hi;
        logic [2:0]  count;
        logic        rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } tx_status_t;

    function automatic logic is_mmio(input logic [31:0] addr);
        return addr[31:2] == MMIO_BASE[31:2];
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte FIFO feeding the transmit port; head, count and flags come straight from registers.
// Latency: a push is visible at the head one edge later; a pop retires the head on the edge.
// Backpressure: push while full is accepted only if a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int DAT_W = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [DAT_W-1:0]           i_push_dat,
    input  logic                       i_pop,
    output logic [DAT_W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rp];

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= i_push_dat;
        end
    end

    // Pointers are power-of-two wide so they wrap on their own.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop_ok) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus LED/counter/TX-FIFO window (enabled by DMEM_MMIO_EN).
// Latency: one cycle, q_dmem registered on the sampling edge; RAM is read-first.
// Backpressure: none on the processor side; TX bytes drain on tx_valid && tx_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH    = DMEM_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_q;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mmio_sel;
    logic [31:0]       w_mmio_rdat;
    logic              w_ram_we;

    assign w_idx    = address_dmem[ADDR_W-1:0];
    assign w_ram_we = wren && !reset && !w_mmio_sel;

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= data;
        end
    end

    // Reading the array in the same edge as the write yields the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (w_mmio_sel) begin
            r_q <= w_mmio_rdat;
        end else begin
            r_q <= r_mem[w_idx];
        end
    end

    assign q_dmem = r_q;

`ifdef DMEM_MMIO_EN
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    mmio_ofs_e         w_ofs;
    logic              w_wr;
    logic [15:0]       r_led;
    logic [31:0]       r_cnt;
    logic              r_ovf;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_head;
    logic [CNT_W-1:0]  w_count;
    tx_status_t        w_sts;

    assign w_mmio_sel = is_mmio(address_dmem);
    assign w_ofs      = mmio_ofs_e'(address_dmem[1:0]);
    assign w_wr       = wren && w_mmio_sel;
    assign w_push     = w_wr && (w_ofs == OFS_TXD);
    assign w_pop      = !w_empty && tx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_wr && (w_ofs == OFS_LED)) begin
            r_led <= data[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wr && (w_ofs == OFS_CNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // A full-FIFO push only counts as lost when no pop frees a slot on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wr && (w_ofs == OFS_TXS)) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    tx_fifo #(
        .DEPTH (TX_DEPTH),
        .DAT_W (8)
    ) u_tx_fifo (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_push     (w_push),
        .i_push_dat (data[7:0]),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_sts       = '0;
        w_sts.empty = w_empty;
        w_sts.full  = w_full;
        w_sts.ovf   = r_ovf;
        w_sts.count = 3'(w_count);
    end

    always_comb begin
        w_mmio_rdat = '0;
        case (w_ofs)
            OFS_LED: w_mmio_rdat = {16'b0, r_led};
            OFS_CNT: w_mmio_rdat = r_cnt;
            OFS_TXD: w_mmio_rdat = '0;
            OFS_TXS: w_mmio_rdat = w_sts;
            default: w_mmio_rdat = '0;
        endcase
    end

    assign led      = r_led;
    assign tx_valid = !w_empty;
    assign tx_data  = w_head;
`else
    logic w_unused;

    assign w_mmio_sel  = 1'b0;
    assign w_mmio_rdat = '0;
    assign led         = '0;
    assign tx_data     = '0;
    assign tx_valid    = 1'b0;
    assign w_unused    = ^{tx_ready, address_dmem[31:ADDR_W], TX_DEPTH[0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: read data and TX bytes are checked against scoreboards.
module tb_dmem_responder;

    localparam int DEPTH = 4096;

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] EXP_LED_RD   = 32'h0000_BEEF;
    localparam logic [31:0] EXP_LED_PIN  = 32'h0000_BEEF;
    localparam logic [31:0] EXP_POST_RST = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_LED_RD   = 32'hABCD_BEEF;
    localparam logic [31:0] EXP_LED_PIN  = 32'h0000_0000;
    localparam logic [31:0] EXP_POST_RST = 32'hABCD_BEEF;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q_sb [$];
    logic [7:0]  tx_sb [$];
    logic [31:0] pat [4];

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH    (DEPTH),
        .TX_DEPTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .led          (led),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One processor cycle: drive on the falling edge, check q_dmem just after the rising edge.
    task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic chk, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clock);
        address_dmem = a;
        data         = d;
        wren         = we;
        if (chk) q_sb.push_back(exp);
        if (tx_valid && tx_ready) begin
            if (tx_sb.size() != 0) e = {24'b0, tx_sb.pop_front()};
            else                   e = 32'hFFFF_FFFF;
            check("tx_pop", {24'b0, tx_data}, e);
        end
        @(posedge clock);
        #1;
        if (chk) begin
            e = q_sb.pop_front();
            check(tag, q_dmem, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        wren         = 1'b0;
        address_dmem = '0;
        data         = '0;
        tx_ready     = 1'b0;

        cyc("rst_q", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        cyc("rst_q_wr", 32'hFFFF_FF00, 32'h5555, 1'b1, 1'b1, 32'h0);
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_txv", {31'b0, tx_valid}, 32'h0);
        reset = 1'b0;

`ifdef DMEM_MMIO_EN
        repeat (10) cyc("idle", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("cnt_10", 32'hFFFF_FF01, 32'h0, 1'b0, 1'b1, 32'd10);
        cyc("cnt_wr", 32'hFFFF_FF01, 32'h1234, 1'b1, 1'b0, 32'h0);
        cyc("cnt_clr", 32'hFFFF_FF01, 32'h0, 1'b0, 1'b1, 32'h0);
        force dut.r_cnt = 32'hFFFF_FFFF;
        cyc("cnt_frc", 32'hFFFF_FF01, 32'h0, 1'b0, 1'b0, 32'h0);
        release dut.r_cnt;
        cyc("cnt_max", 32'hFFFF_FF01, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc("cnt_wrap", 32'hFFFF_FF01, 32'h0, 1'b0, 1'b1, 32'h0);
`endif

        cyc("ram_wr5", 32'd5, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        cyc("ram_rd5", 32'd5, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        cyc("ram_alias", 32'd5 + DEPTH, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        cyc("ram_wr9", 32'd9, 32'h11, 1'b1, 1'b0, 32'h0);
        cyc("ram_rdfirst", 32'd9, 32'hAA, 1'b1, 1'b1, 32'h11);
        cyc("ram_rd9", 32'd9, 32'h0, 1'b0, 1'b1, 32'hAA);

        for (int i = 0; i < 4; i++) begin
            pat[i] = 32'hC0DE_0000 ^ (32'h0101_0111 * (i + 1));
            cyc("ram_pat_wr", 32'd200 + i, pat[i], 1'b1, 1'b0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc("ram_pat_rd", 32'd200 + i + 2 * DEPTH, 32'h0, 1'b0, 1'b1, pat[i]);
        end

        cyc("led_wr", 32'hFFFF_FF00, 32'hABCD_BEEF, 1'b1, 1'b0, 32'h0);
        cyc("led_rd", 32'hFFFF_FF00, 32'h0, 1'b0, 1'b1, EXP_LED_RD);
        check("led_pin", {16'b0, led}, EXP_LED_PIN);

`ifdef DMEM_MMIO_EN
        for (int b = 8'h41; b <= 8'h45; b++) begin
            if (b != 8'h45) tx_sb.push_back(8'(b));
            cyc("txd_wr", 32'hFFFF_FF02, 32'(b), 1'b1, 1'b0, 32'h0);
        end
        cyc("txs_full_ovf", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h46);
        check("tx_head", {24'b0, tx_data}, 32'h41);
        check("txv_full", {31'b0, tx_valid}, 32'h1);
        cyc("txd_rd", 32'hFFFF_FF02, 32'h0, 1'b0, 1'b1, 32'h0);

        tx_ready = 1'b1;
        repeat (4) cyc("drain", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("txv_drained", {31'b0, tx_valid}, 32'h0);
        check("tx_all_popped", tx_sb.size(), 32'h0);
        tx_ready = 1'b0;
        cyc("txs_ovf_sticky", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h05);
        cyc("txs_wr", 32'hFFFF_FF03, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc("txs_ovf_clr", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h01);

        for (int b = 8'h50; b <= 8'h53; b++) begin
            tx_sb.push_back(8'(b));
            cyc("txd_wr2", 32'hFFFF_FF02, 32'(b), 1'b1, 1'b0, 32'h0);
        end
        tx_ready = 1'b1;
        tx_sb.push_back(8'h54);
        cyc("txd_pushpop", 32'hFFFF_FF02, 32'h54, 1'b1, 1'b0, 32'h0);
        tx_ready = 1'b0;
        cyc("txs_pushpop", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h42);
        check("tx_head2", {24'b0, tx_data}, 32'h51);
        tx_ready = 1'b1;
        cyc("pop1", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tx_ready = 1'b0;
        cyc("txs_cnt3", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h30);
`else
        check("tx_data_tied", {24'b0, tx_data}, 32'h0);
        check("txv_tied", {31'b0, tx_valid}, 32'h0);
`endif

        reset = 1'b1;
        cyc("rst_mid_q", 32'hFFFF_FF00, 32'h1234, 1'b1, 1'b1, 32'h0);
        reset = 1'b0;
        tx_sb.delete();
        check("rst_mid_txv", {31'b0, tx_valid}, 32'h0);
        check("rst_mid_led", {16'b0, led}, 32'h0);
        cyc("led_after_rst", 32'hFFFF_FF00, 32'h0, 1'b0, 1'b1, EXP_POST_RST);
`ifdef DMEM_MMIO_EN
        cyc("txs_after_rst", 32'hFFFF_FF03, 32'h0, 1'b0, 1'b1, 32'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the processor's data-memory port. It accepts `address_dmem`/`data`/`wren` from the pipeline's XM stage and returns `q_dmem` for the MW stage. The word-addressed RAM sits behind a memory-mapped I/O window: a LED register, a free-running cycle counter and a byte transmit FIFO. It is instantiated in Wrapper beside the imem and the RegFile.

## Interface
Parameters:
- `DEPTH`, 4096: RAM words (power of two); `ADDR_W = log2(DEPTH)`.
- `TX_DEPTH`, 4: TX FIFO entries (power of two, at least 2).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clock`  in  1  master clock; all state updates on the rising edge.
  - `reset`  in  1  synchronous, active-high.
- Processor port:
  - `address_dmem`  in  32  word address.
  - `data`  in  32  store data.
  - `wren`  in  1  write enable.
  - `q_dmem`  out  32  registered read data.
- Peripheral outputs:
  - `led`  out  16  LED register.
  - `tx_data`  out  8  FIFO head byte.
  - `tx_valid`  out  1  FIFO non-empty.
  - `tx_ready`  in  1  downstream accepts byte.

## Operation
- Address decode:
  - `address_dmem` in 0xFFFF_FF00–0xFFFF_FF03 selects MMIO.
  - All other addresses select RAM word `address_dmem[ADDR_W-1:0]`. Upper bits are ignored, so addresses alias.
- RAM:
  - Write `data` when `wren`.
  - Read is read-first: a same-edge write returns the old word.
  - Contents are not reset.
- 0xFF00 LED (R/W):
  - A write loads `data[15:0]`.
  - A read returns the value zero-extended.
- 0xFF01 cycle counter (R/W):
  - 32-bit, +1 every edge, wraps 0xFFFF_FFFF→0.
  - A write clears it to 0 and takes priority over the increment.
  - A read returns the pre-edge value.
- 0xFF02 TX data (W):
  - A write pushes `data[7:0]`.
  - If the FIFO is full and no pop occurs on the same edge, the push is dropped and sticky `ovf` is set.
  - A read returns 0.
- 0xFF03 TX status (R/W):
  - Read returns bit0 empty, bit1 full, bit2 `ovf`, bits[6:4] count, other bits 0.
  - Any write clears `ovf`.
- TX FIFO:
  - `tx_valid` = !empty and `tx_data` = head, both combinational from the FIFO registers.
  - A pop occurs when `tx_valid && tx_ready` at an edge.
  - Push and pop on the same edge: both take effect and the count is unchanged, including when full.
  - Pop when empty: no effect.
  - Read and write pointers wrap modulo `TX_DEPTH`.
- Reset:
  - Outputs: `q_dmem`=0, `led`=0, `tx_valid`=0.
  - Internal state: counter 0, FIFO empty, `ovf`=0.
  - A `wren` during reset is ignored. Reset mid-stream discards queued bytes.

## Timing
- `address_dmem`, `data` and `wren` are sampled at rising edge k. The processor drives them from falling-edge XM registers.
- `q_dmem` is valid from edge k until edge k+1: one-cycle read latency, captured by MW on the following falling edge.
- Register/counter/FIFO state written at edge k is visible to a read at edge k+1.
- TX status read at edge k reflects state before edge k's push or pop.
- `tx_data` changes only on a rising edge.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO window decoded as above.
- `DMEM_MMIO_EN` undefined:
  - Every address, including 0xFFFF_FFxx, aliases into RAM.
  - `led` ties to 0, `tx_valid` to 0 and `tx_data` to 0.
  - The counter and FIFO are not instantiated.

## Structure
- Package `dmem_pkg`:
  - MMIO base and offsets (LED, CNT, TXD, TXS).
  - Status bit positions.
  - `DEPTH` and `TX_DEPTH` defaults.
- One sub-module, `tx_fifo` (push, pop, head, count, full, empty), parameterised by `TX_DEPTH`.
- RAM is inferred inside `dmem_responder`.

## Test plan
- RAM: write 0x1234_5678 to addr 5 at edge k; read addr 5 at edge k+1 → `q_dmem`=0x1234_5678 after edge k+1. Read 5+`DEPTH` → same value (alias).
- Read-first: write 0xAA to addr 9 (old 0x11) with read of addr 9 on the same edge → `q_dmem`=0x11; next read → 0xAA.
- Counter:
  - Release reset, then 10 idle edges, then read 0xFFFF_FF01 → 10.
  - Write 0xFFFF_FF01 → next read returns 0.
  - Preload via force to 0xFFFF_FFFF and run one edge → 0.
- FIFO, `tx_ready`=0:
  - Push 0x41, 0x42, 0x43, 0x44, then 0x45 → status 0x46 (count 4, full, ovf); `tx_data`=0x41.
  - Raise `tx_ready` → bytes 0x41–0x44 drained in order; `tx_valid` falls after the 4th.
- Full FIFO with `tx_ready`=1 and a push on the same edge → push accepted, count stays 4, `ovf` unchanged. A write to 0xFFFF_FF03 clears `ovf`.
- Reset asserted with 3 bytes queued and `wren`=1 to LED → `tx_valid`=0, `led`=0, `q_dmem`=0 after that edge. Repeat with `DMEM_MMIO_EN` undefined: write to 0xFFFF_FF00 reads back from RAM word 0xF00 (mod `DEPTH`).
